// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU accumulator: default lane widths and the
// accumulator control-state encoding.
package tpu_pkg;

  localparam int DEF_MATRIX_SIZE    = 8;
  localparam int DEF_PARTIAL_SUM_BW = 20;
  localparam int DEF_ACC_BW         = 24;
  localparam int DEF_ACC_DEPTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_e;

endpackage

// File: rtl/sat_add_lane.sv
// One accumulator lane: sign-extends a partial sum to the accumulator width
// and either passes it through (overwrite) or adds it to the stored value
// with saturation to the signed accumulator range.
module sat_add_lane
  import tpu_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
  parameter int ACC_BW         = DEF_ACC_BW
) (
  input  logic [PARTIAL_SUM_BW-1:0] psum,
  input  logic [ACC_BW-1:0]         acc,
  input  logic                      overwrite,
  output logic [ACC_BW-1:0]         sum,
  output logic                      sat
);

  logic signed [PARTIAL_SUM_BW-1:0] psum_s;
  logic signed [ACC_BW-1:0]         psum_ext;
  logic signed [ACC_BW-1:0]         acc_s;
  logic signed [ACC_BW:0]           wide;

  // Clamp a one-bit-wider sum back into the accumulator range.
  function automatic logic signed [ACC_BW-1:0] saturate(input logic signed [ACC_BW:0] v);
    if (v[ACC_BW] != v[ACC_BW-1])
      return v[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
    return v[ACC_BW-1:0];
  endfunction

  // The two top bits of the widened sum disagree exactly when it overflowed.
  function automatic logic overflowed(input logic signed [ACC_BW:0] v);
    return v[ACC_BW] ^ v[ACC_BW-1];
  endfunction

  assign psum_s   = psum;
  assign acc_s    = acc;
  assign psum_ext = ACC_BW'(psum_s);
  assign wide     = (ACC_BW+1)'(acc_s) + (ACC_BW+1)'(psum_ext);

  // Select overwrite or saturated accumulate; only accumulation can saturate.
  always_comb begin
    sum = overwrite ? psum_ext : saturate(wide);
    sat = !overwrite && overflowed(wide);
  end

endmodule

// File: rtl/tpu_accumulator.sv
// Accumulator bank behind the systolic array. Incoming partial-sum vectors
// are either written or added into a row; a flush drains every row in order
// through a valid/ready port and clears each row as it leaves.
// The read of the target row is registered together with the input vector,
// so the sum is formed one cycle after acceptance; a back-to-back accept to
// the same row picks up that in-flight sum instead of the stale stored row.
module tpu_accumulator
  import tpu_pkg::*;
#(
  parameter  int MATRIX_SIZE    = DEF_MATRIX_SIZE,
  parameter  int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
  parameter  int ACC_BW         = DEF_ACC_BW,
  parameter  int ACC_DEPTH      = DEF_ACC_DEPTH,
  localparam int ADDR_BW        = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
  input  logic [ADDR_BW-1:0]                 in_addr,
  input  logic                               in_overwrite,
  input  logic                               flush_start,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ACC_BW*MATRIX_SIZE-1:0]      out_data,
  output logic [ADDR_BW-1:0]                 out_addr,
  output logic                               busy,
  output logic                               flush_done,
  output logic                               sat_flag
);

  localparam int IN_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int ROW_W = ACC_BW * MATRIX_SIZE;
  localparam logic [ADDR_BW-1:0] LAST_ROW = ADDR_BW'(ACC_DEPTH - 1);

  acc_state_e         state;
  logic [ADDR_BW-1:0] flush_ptr;
  logic [ROW_W-1:0]   rows [ACC_DEPTH];

  logic               accept;
  logic               flush_go;
  logic               drain_hs;

  logic               vld_p0;
  logic [ADDR_BW-1:0] addr_p0;
  logic [IN_W-1:0]    data_p0;
  logic               ow_p0;
  logic [ROW_W-1:0]   acc_p0;

  logic [ROW_W-1:0]       sum_p0;
  logic [MATRIX_SIZE-1:0] sat_p0;

  logic [ROW_W-1:0]   rd_fwd;
  logic [ROW_W-1:0]   drain_row;

  assign accept   = in_valid & in_ready;
  assign flush_go = flush_start & in_ready;
  assign drain_hs = out_valid & out_ready;

  // A row still being written by the sum stage is taken from that stage.
  assign rd_fwd    = (vld_p0 && addr_p0 == in_addr)   ? sum_p0 : rows[in_addr];
  assign drain_row = (vld_p0 && addr_p0 == flush_ptr) ? sum_p0 : rows[flush_ptr];

  assign out_data = out_valid ? drain_row : '0;
  assign out_addr = flush_ptr;

  // Control FSM with registered handshake/status outputs and the drain pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
      flush_ptr  <= '0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (flush_start) begin
            state     <= ST_FLUSH;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            flush_ptr <= '0;
          end else if (state == ST_IDLE && in_valid) begin
            state <= ST_ACCUM;
          end
        end
        ST_FLUSH: begin
          if (out_ready) begin
            if (flush_ptr == LAST_ROW) begin
              state      <= ST_DONE;
              out_valid  <= 1'b0;
              flush_done <= 1'b1;
            end else begin
              flush_ptr <= flush_ptr + ADDR_BW'(1);
            end
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0 valid: a reset drops any vector that has not yet been written.
  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= accept;
  end

  // Stage p0 data: capture the accepted vector and its (forwarded) row operand.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0 <= in_addr;
      data_p0 <= in_data;
      ow_p0   <= in_overwrite;
      acc_p0  <= rd_fwd;
    end
  end

  for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_lane
    sat_add_lane #(
      .PARTIAL_SUM_BW(PARTIAL_SUM_BW),
      .ACC_BW        (ACC_BW)
    ) u_lane (
      .psum     (data_p0[g*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
      .acc      (acc_p0[g*ACC_BW +: ACC_BW]),
      .overwrite(ow_p0),
      .sum      (sum_p0[g*ACC_BW +: ACC_BW]),
      .sat      (sat_p0[g])
    );
  end

  // Sticky saturation flag; a new flush starts a fresh observation window.
  always_ff @(posedge clk) begin
    if (rst) sat_flag <= 1'b0;
    else     sat_flag <= (sat_flag & ~flush_go) | (vld_p0 & (|sat_p0));
  end

  // Row storage: commit the p0 sum, then clear a row as it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ACC_DEPTH; i++) rows[i] <= '0;
    end else begin
      if (vld_p0)   rows[addr_p0]   <= sum_p0;
      if (drain_hs) rows[flush_ptr] <= '0;
    end
  end

endmodule

// File: tb/tb_tpu_accumulator.sv
// Directed bench for tpu_accumulator at default parameters.
module tb_tpu_accumulator;

  localparam int MS    = 8;
  localparam int PW    = 20;
  localparam int AW    = 24;
  localparam int DEPTH = 16;
  localparam int ABW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [PW*MS-1:0]  in_data;
  logic [ABW-1:0]    in_addr;
  logic              in_overwrite;
  logic              flush_start;
  logic              out_valid;
  logic              out_ready;
  logic [AW*MS-1:0]  out_data;
  logic [ABW-1:0]    out_addr;
  logic              busy;
  logic              flush_done;
  logic              sat_flag;

  int errors = 0;
  int checks = 0;
  logic [AW*MS-1:0] drained [DEPTH];

  always #5 clk = ~clk;

  tpu_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_addr     (in_addr),
    .in_overwrite(in_overwrite),
    .flush_start (flush_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .busy        (busy),
    .flush_done  (flush_done),
    .sat_flag    (sat_flag)
  );

  function automatic logic [PW*MS-1:0] psum_vec(input int v);
    logic [PW*MS-1:0] r;
    for (int i = 0; i < MS; i++) r[i*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic logic [PW*MS-1:0] psum_lane0(input int v);
    logic [PW*MS-1:0] r;
    r = '0;
    r[PW-1:0] = PW'(v);
    return r;
  endfunction

  function automatic logic [AW*MS-1:0] acc_vec(input int v);
    logic [AW*MS-1:0] r;
    for (int i = 0; i < MS; i++) r[i*AW +: AW] = AW'(v);
    return r;
  endfunction

  task automatic send(input logic [ABW-1:0] a, input logic ow, input logic [PW*MS-1:0] d);
    in_valid     = 1'b1;
    in_addr      = a;
    in_overwrite = ow;
    in_data      = d;
    @(posedge clk); #1;
    in_valid     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Drain all rows into drained[]; optionally start the flush and stall the consumer.
  task automatic drain(input bit start, input bit toggle);
    int idx, cyc, bad_valid, bad_ready, bad_order, bad_stable;
    bit stalled;
    logic [AW*MS-1:0] held_data;
    logic [ABW-1:0]   held_addr;
    idx = 0; cyc = 0; bad_valid = 0; bad_ready = 0; bad_order = 0; bad_stable = 0;
    stalled = 1'b0; held_data = '0; held_addr = '0;
    if (start) begin
      flush_start = 1'b1;
      @(posedge clk); #1;
      flush_start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL flush_busy got=%0b exp=1", busy);
    end
    while (idx < DEPTH && cyc < 200) begin
      out_ready   = toggle ? (cyc % 2 == 0) : 1'b1;
      flush_start = (toggle && cyc == 5);
      if (out_valid !== 1'b1) bad_valid++;
      if (in_ready !== 1'b0) bad_ready++;
      if (out_addr !== ABW'(idx)) bad_order++;
      if (stalled && (out_data !== held_data || out_addr !== held_addr)) bad_stable++;
      if (out_valid === 1'b1 && out_ready) begin
        drained[idx] = out_data;
        idx++;
        stalled = 1'b0;
      end else begin
        stalled   = 1'b1;
        held_data = out_data;
        held_addr = out_addr;
      end
      @(posedge clk); #1;
      cyc++;
    end
    flush_start = 1'b0;
    checks++;
    if (idx != DEPTH) begin
      errors++; $display("FAIL drain_rows_count got=%0d exp=%0d", idx, DEPTH);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++; $display("FAIL drain_out_valid low_cycles got=%0d exp=0", bad_valid);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL drain_in_ready high_cycles got=%0d exp=0", bad_ready);
    end
    checks++;
    if (bad_order != 0) begin
      errors++; $display("FAIL drain_row_order bad_cycles got=%0d exp=0", bad_order);
    end
    checks++;
    if (bad_stable != 0) begin
      errors++; $display("FAIL drain_stall_stable bad_cycles got=%0d exp=0", bad_stable);
    end
    checks++;
    if (flush_done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_state flush_done=%0b out_valid=%0b busy=%0b exp 1/0/1",
               flush_done, out_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (flush_done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle flush_done=%0b in_ready=%0b busy=%0b exp 0/1/0",
               flush_done, in_ready, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_addr = '0; in_overwrite = 1'b0;
    flush_start = 1'b0; out_ready = 1'b0;
    idle(2);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++;
    if (out_addr !== '0) begin errors++; $display("FAIL reset_out_addr got=%0d exp=0", out_addr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++;
    if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got=%0b exp=0", flush_done); end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got=%0b exp=0", sat_flag); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_overwrite_accumulate();
    send(4'd3, 1'b1, psum_vec(5));
    send(4'd3, 1'b0, psum_vec(7));
    send(4'd9, 1'b1, psum_vec(-3));
    idle(1);
    send(4'd9, 1'b0, psum_vec(10));
    idle(2);
    drain(1'b1, 1'b0);
    for (int r = 0; r < DEPTH; r++) begin
      logic [AW*MS-1:0] exp_row;
      exp_row = (r == 3) ? acc_vec(12) : (r == 9) ? acc_vec(7) : '0;
      checks++;
      if (drained[r] !== exp_row) begin
        errors++; $display("FAIL ow_acc_row%0d got=%h exp=%h", r, drained[r], exp_row);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(4'd0, 1'b1, psum_vec(1));
    send(4'd0, 1'b0, psum_vec(2));
    send(4'd0, 1'b0, psum_vec(3));
    idle(2);
    drain(1'b1, 1'b0);
    checks++;
    if (drained[0] !== acc_vec(6)) begin
      errors++; $display("FAIL b2b_row0 got=%h exp=%h", drained[0], acc_vec(6));
    end
  endtask

  task automatic test_saturation();
    logic [AW*MS-1:0] exp_pos, exp_neg;
    exp_pos = '0; exp_pos[AW-1:0] = 24'h7F_FFFF;
    exp_neg = '0; exp_neg[AW-1:0] = 24'h80_0000;
    send(4'd0, 1'b1, psum_lane0(524287));
    repeat (15) send(4'd0, 1'b0, psum_lane0(524287));
    send(4'd0, 1'b0, psum_lane0(15));
    idle(2);
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_at_max_no_flag got=%0b exp=0", sat_flag); end
    send(4'd0, 1'b0, psum_lane0(1));
    idle(2);
    checks++;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set got=%0b exp=1", sat_flag); end
    send(4'd1, 1'b1, psum_lane0(-524288));
    repeat (18) send(4'd1, 1'b0, psum_lane0(-524288));
    idle(2);
    drain(1'b1, 1'b0);
    checks++;
    if (drained[0] !== exp_pos) begin
      errors++; $display("FAIL sat_pos_row0 got=%h exp=%h", drained[0], exp_pos);
    end
    checks++;
    if (drained[1] !== exp_neg) begin
      errors++; $display("FAIL sat_neg_row1 got=%h exp=%h", drained[1], exp_neg);
    end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_cleared got=%0b exp=0", sat_flag); end
  endtask

  task automatic test_flush_stall();
    for (int r = 0; r < DEPTH; r++) send(ABW'(r), 1'b1, psum_vec(r*3 + 1));
    idle(2);
    drain(1'b1, 1'b1);
    for (int r = 0; r < DEPTH; r++) begin
      checks++;
      if (drained[r] !== acc_vec(r*3 + 1)) begin
        errors++; $display("FAIL stall_row%0d got=%h exp=%h", r, drained[r], acc_vec(r*3 + 1));
      end
    end
  endtask

  task automatic test_flush_with_accept();
    send(4'd2, 1'b1, psum_vec(1));
    in_valid = 1'b1; in_addr = 4'd2; in_overwrite = 1'b0; in_data = psum_vec(4);
    flush_start = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush_start = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_in_ready got=%0b exp=0", in_ready); end
    drain(1'b0, 1'b0);
    checks++;
    if (drained[2] !== acc_vec(5)) begin
      errors++; $display("FAIL same_cycle_row2 got=%h exp=%h", drained[2], acc_vec(5));
    end
  endtask

  task automatic test_reset_mid_flush();
    int cyc;
    int nonzero;
    send(4'd10, 1'b1, psum_vec(9));
    send(4'd2, 1'b1, psum_vec(4));
    idle(1);
    out_ready = 1'b1;
    flush_start = 1'b1;
    @(posedge clk); #1;
    flush_start = 1'b0;
    cyc = 0;
    while (out_addr !== 4'd7 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (out_addr !== 4'd7 || out_valid !== 1'b1) begin
      errors++; $display("FAIL reach_row7 got_addr=%0d got_valid=%0b exp 7/1", out_addr, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state out_valid=%0b busy=%0b in_ready=%0b exp 0/0/1", out_valid, busy, in_ready);
    end
    send(4'd5, 1'b1, psum_vec(9));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    drain(1'b1, 1'b0);
    nonzero = 0;
    for (int r = 0; r < DEPTH; r++) if (drained[r] !== '0) nonzero++;
    checks++;
    if (nonzero != 0) begin
      errors++; $display("FAIL post_reset_rows_zero nonzero_rows got=%0d exp=0", nonzero);
    end
  endtask

  initial begin
    test_reset();
    test_overwrite_accumulate();
    test_back_to_back();
    test_saturation();
    test_flush_stall();
    test_flush_with_accept();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
